// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: ID-stage decode fields and EX jump resolution going into
// the hazard controller, and the stall / bubble / forwarding controls coming
// back out.
//   master : pipeline side (drives id_* and ex_jump_taken, reads controls)
//   slave  : hazard_ctrl side
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] id_rd_addr;
    logic                  id_writeback_en;
    logic                  id_writeback_from_mem;
    logic                  ex_jump_taken;

    logic                  skip;
    logic                  skip_instr;
    logic                  rs1_take_prev1;
    logic                  rs2_take_prev1;
    logic                  rs1_take_prev2;
    logic                  rs2_take_prev2;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_writeback_en, id_writeback_from_mem, ex_jump_taken,
        input  skip, skip_instr, rs1_take_prev1, rs2_take_prev1,
               rs1_take_prev2, rs2_take_prev2
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_writeback_en, id_writeback_from_mem, ex_jump_taken,
        output skip, skip_instr, rs1_take_prev1, rs2_take_prev1,
               rs1_take_prev2, rs2_take_prev2
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard and forwarding controller beside the ID/EX register.
// Tracks the destinations of the instructions in EX (h1) and MEM (h2) and
// decides, in the same cycle as the ID inputs, whether the ID instruction is
// forwarded, stalled on a load-use dependency, or squashed after a taken jump.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset; forces all outputs to 0 while high
//   bus  : hazard_ctrl_if.slave (ID fields, ex_jump_taken in; skip,
//          skip_instr and rsN_take_prevM out)
module hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int LOAD_STALL   = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  wb_en;
        logic                  from_mem;
    } hist_t;

    localparam logic [1:0] STALL_LOAD = 2'(LOAD_STALL - 1);
    localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    hist_t      h1_q, h1_d, h2_q;

    logic rs1_m1, rs2_m1, rs1_m2, rs2_m2;
    logic load_use, skip, skip_instr;

    function automatic logic src_match(input hist_t h, input logic used,
                                       input logic [REG_ADDR_W-1:0] addr);
        return used && (addr != '0) && h.valid && h.wb_en && (h.rd == addr);
    endfunction

    assign rs1_m1 = src_match(h1_q, bus.id_rs1_used, bus.id_rs1_addr);
    assign rs2_m1 = src_match(h1_q, bus.id_rs2_used, bus.id_rs2_addr);
    assign rs1_m2 = src_match(h2_q, bus.id_rs1_used, bus.id_rs1_addr);
    assign rs2_m2 = src_match(h2_q, bus.id_rs2_used, bus.id_rs2_addr);

    // A load in EX has no result yet, so a consumer in ID must wait.
    assign load_use = bus.id_valid && h1_q.from_mem && (rs1_m1 || rs2_m1);

    always_comb begin
        skip       = 1'b0;
        skip_instr = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        case (state_q)
            RUN: begin
                if (bus.ex_jump_taken) begin
                    skip_instr = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (load_use) begin
                    skip       = 1'b1;
                    skip_instr = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_LOAD;
                    end
                end else begin
                    skip_instr = !bus.id_valid;
                end
            end
            STALL: begin
                skip_instr = 1'b1;
                if (bus.ex_jump_taken) begin
                    // The stalled instruction is on the wrong path: drop it.
                    if (FLUSH_CYCLES > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end else begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end
                end else begin
                    skip  = 1'b1;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end
                end
            end
            FLUSH: begin
                skip_instr = 1'b1;
                if (bus.ex_jump_taken) begin
                    cnt_d = FLUSH_LOAD;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                        cnt_d   = 2'd0;
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        h1_d = '0;
        if (bus.id_valid && !skip_instr) begin
            h1_d.valid    = 1'b1;
            h1_d.rd       = bus.id_rd_addr;
            h1_d.wb_en    = bus.id_writeback_en;
            h1_d.from_mem = bus.id_writeback_from_mem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            h1_q    <= '0;
            h2_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            h1_q    <= h1_d;
            h2_q    <= h1_q;
        end
    end

    // Younger producer (EX) wins over MEM; a load in EX never forwards.
    assign bus.skip           = !rst && skip;
    assign bus.skip_instr     = !rst && skip_instr;
    assign bus.rs1_take_prev1 = !rst && !skip_instr && rs1_m1 && !h1_q.from_mem;
    assign bus.rs2_take_prev1 = !rst && !skip_instr && rs2_m1 && !h1_q.from_mem;
    assign bus.rs1_take_prev2 = !rst && !skip_instr && rs1_m2 && !rs1_m1;
    assign bus.rs2_take_prev2 = !rst && !skip_instr && rs2_m2 && !rs2_m1;
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int W  = 5;
    localparam int FC = 2;

    typedef struct {
        bit v; bit [W-1:0] rs1; bit u1; bit [W-1:0] rs2; bit u2;
        bit [W-1:0] rd; bit wb; bit ld;
    } ins_t;

    typedef struct { bit v; bit [W-1:0] rd; bit wb; bit ld; } h_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         d_valid, d_u1, d_u2, d_wb, d_ld, d_jmp;
    logic [W-1:0] d_rs1, d_rs2, d_rd;

    hazard_ctrl_if #(.REG_ADDR_W(W)) bus_a ();
    hazard_ctrl_if #(.REG_ADDR_W(W)) bus_b ();

    assign bus_a.id_valid = d_valid;  assign bus_b.id_valid = d_valid;
    assign bus_a.id_rs1_addr = d_rs1; assign bus_b.id_rs1_addr = d_rs1;
    assign bus_a.id_rs2_addr = d_rs2; assign bus_b.id_rs2_addr = d_rs2;
    assign bus_a.id_rs1_used = d_u1;  assign bus_b.id_rs1_used = d_u1;
    assign bus_a.id_rs2_used = d_u2;  assign bus_b.id_rs2_used = d_u2;
    assign bus_a.id_rd_addr = d_rd;   assign bus_b.id_rd_addr = d_rd;
    assign bus_a.id_writeback_en = d_wb;       assign bus_b.id_writeback_en = d_wb;
    assign bus_a.id_writeback_from_mem = d_ld; assign bus_b.id_writeback_from_mem = d_ld;
    assign bus_a.ex_jump_taken = d_jmp;        assign bus_b.ex_jump_taken = d_jmp;

    hazard_ctrl #(.REG_ADDR_W(W), .LOAD_STALL(1), .FLUSH_CYCLES(FC))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    hazard_ctrl #(.REG_ADDR_W(W), .LOAD_STALL(3), .FLUSH_CYCLES(FC))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    // {skip, skip_instr, rs1_p1, rs2_p1, rs1_p2, rs2_p2}
    wire [5:0] out_a = {bus_a.skip, bus_a.skip_instr, bus_a.rs1_take_prev1,
                        bus_a.rs2_take_prev1, bus_a.rs1_take_prev2, bus_a.rs2_take_prev2};
    wire [5:0] out_b = {bus_b.skip, bus_b.skip_instr, bus_b.rs1_take_prev1,
                        bus_b.rs2_take_prev1, bus_b.rs1_take_prev2, bus_b.rs2_take_prev2};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the two instructions downstream of ID plus how many
    // more stall / squash cycles are owed.
    int   LS [2] = '{1, 3};
    h_t   ex1 [2], ex2 [2], n_ex1 [2];
    int   srem [2], frem [2], n_srem [2], n_frem [2];
    logic [5:0] exp_o [2];

    function automatic ins_t mk(bit v, int rs1, bit u1, int rs2, bit u2, int rd, bit wb, bit ld);
        ins_t i;
        i.v = v; i.rs1 = W'(rs1); i.u1 = u1; i.rs2 = W'(rs2); i.u2 = u2;
        i.rd = W'(rd); i.wb = wb; i.ld = ld;
        return i;
    endfunction

    function automatic bit hit(h_t e, bit used, bit [W-1:0] a);
        return used && a != 0 && e.v && e.wb && e.rd == a;
    endfunction

    // Returns {from EX, from MEM} for one source: youngest writer wins,
    // a load still in EX cannot supply data.
    function automatic bit [1:0] fwd(h_t e1, h_t e2, bit used, bit [W-1:0] a);
        if (hit(e1, used, a)) return {!e1.ld, 1'b0};
        if (hit(e2, used, a)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ex1[k] = '{default: 0}; ex2[k] = '{default: 0};
            srem[k] = 0; frem[k] = 0;
        end
    endtask

    task automatic model_eval(input int k, input ins_t i, input bit j);
        bit sk, si, lu;
        bit [1:0] f1, f2;
        lu = i.v && ex1[k].ld && (hit(ex1[k], i.u1, i.rs1) || hit(ex1[k], i.u2, i.rs2));
        n_srem[k] = 0;
        n_frem[k] = 0;
        if (j) begin
            sk = 0; si = 1; n_frem[k] = FC - 1;
        end else if (frem[k] > 0) begin
            sk = 0; si = 1; n_frem[k] = frem[k] - 1;
        end else if (srem[k] > 0) begin
            sk = 1; si = 1; n_srem[k] = srem[k] - 1;
        end else if (lu) begin
            sk = 1; si = 1; n_srem[k] = LS[k] - 1;
        end else begin
            sk = 0; si = !i.v;
        end
        f1 = si ? 2'b00 : fwd(ex1[k], ex2[k], i.u1, i.rs1);
        f2 = si ? 2'b00 : fwd(ex1[k], ex2[k], i.u2, i.rs2);
        exp_o[k] = {sk, si, f1[1], f2[1], f1[0], f2[0]};
        n_ex1[k] = '{default: 0};
        if (i.v && !si) n_ex1[k] = '{v: 1, rd: i.rd, wb: i.wb, ld: i.ld};
    endtask

    task automatic model_commit();
        for (int k = 0; k < 2; k++) begin
            ex2[k] = ex1[k]; ex1[k] = n_ex1[k];
            srem[k] = n_srem[k]; frem[k] = n_frem[k];
        end
    endtask

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (skip,skip_instr,r1p1,r2p1,r1p2,r2p2)", nm, act, exp);
        end
    endtask

    task automatic drive(input ins_t i, input bit j);
        d_valid = i.v; d_rs1 = i.rs1; d_u1 = i.u1; d_rs2 = i.rs2; d_u2 = i.u2;
        d_rd = i.rd; d_wb = i.wb; d_ld = i.ld; d_jmp = j;
    endtask

    // Called at a negedge; drives, checks mid-cycle, advances one clock.
    task automatic step(input ins_t i, input bit j, input string nm,
                        input bit [1:0] lit_en, input logic [5:0] lit_a, input logic [5:0] lit_b);
        drive(i, j);
        #1;
        model_eval(0, i, j);
        model_eval(1, i, j);
        chk({nm, "/a"}, out_a, exp_o[0]);
        chk({nm, "/b"}, out_b, exp_o[1]);
        if (lit_en[0]) chk({nm, "/a_lit"}, out_a, lit_a);
        if (lit_en[1]) chk({nm, "/b_lit"}, out_b, lit_b);
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    initial begin
        ins_t r;
        bit   j;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0), 0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_a", out_a, 6'b0);
        chk("reset_b", out_b, 6'b0);
        rst = 1'b0;

        // Forwarding
        step(mk(1, 1, 1, 2, 1, 5, 1, 0), 0, "add_x5",    2'b11, 6'b000000, 6'b000000);
        step(mk(1, 5, 1, 7, 1, 6, 1, 0), 0, "b2b_alu",   2'b11, 6'b001000, 6'b001000);
        step(mk(1, 1, 1, 2, 1, 5, 1, 0), 0, "add_x5b",   2'b11, 6'b000000, 6'b000000);
        step(mk(1, 0, 0, 0, 0, 0, 0, 0), 0, "nop",       2'b11, 6'b000000, 6'b000000);
        step(mk(1, 9, 1, 5, 1, 8, 1, 0), 0, "two_apart", 2'b11, 6'b000001, 6'b000001);
        step(mk(1, 0, 1, 1, 1, 5, 1, 0), 0, "add_x5c",   2'b11, 6'b000000, 6'b000000);
        step(mk(1, 1, 1, 2, 1, 5, 1, 0), 0, "add_x5d",   2'b11, 6'b000000, 6'b000000);
        step(mk(1, 9, 1, 5, 1, 8, 1, 0), 0, "younger",   2'b11, 6'b000100, 6'b000100);
        // Load-use
        step(mk(1, 1, 1, 0, 0, 3, 1, 1), 0, "load_x3",   2'b11, 6'b000000, 6'b000000);
        step(mk(1, 3, 1, 3, 1, 4, 1, 0), 0, "lu_c1",     2'b11, 6'b110000, 6'b110000);
        step(mk(1, 3, 1, 3, 1, 4, 1, 0), 0, "lu_c2",     2'b11, 6'b000011, 6'b110000);
        step(mk(1, 3, 1, 3, 1, 4, 1, 0), 0, "lu_c3",     2'b11, 6'b000000, 6'b110000);
        step(mk(1, 3, 1, 3, 1, 4, 1, 0), 0, "lu_c4",     2'b11, 6'b000000, 6'b000000);
        // x0 destination
        step(mk(1, 1, 1, 2, 1, 0, 1, 1), 0, "load_x0",   2'b11, 6'b000000, 6'b000000);
        step(mk(1, 0, 1, 0, 1, 9, 1, 0), 0, "read_x0",   2'b11, 6'b000000, 6'b000000);
        // Taken jump
        step(mk(1, 9, 1, 0, 0, 10, 1, 0), 1, "jump",     2'b11, 6'b010000, 6'b010000);
        step(mk(1, 9, 1, 0, 0, 10, 1, 0), 0, "flush1",   2'b11, 6'b010000, 6'b010000);
        step(mk(1, 1, 1, 0, 0, 11, 1, 0), 0, "post_fl",  2'b11, 6'b000000, 6'b000000);
        // Jump during stall
        step(mk(1, 1, 1, 0, 0, 3, 1, 1), 0, "load_x3b",  2'b11, 6'b000000, 6'b000000);
        step(mk(1, 3, 1, 3, 1, 4, 1, 0), 0, "st_lu",     2'b11, 6'b110000, 6'b110000);
        step(mk(1, 3, 1, 3, 1, 4, 1, 0), 1, "st_jump",   2'b11, 6'b010000, 6'b010000);
        step(mk(1, 3, 1, 3, 1, 4, 1, 0), 0, "st_flush",  2'b11, 6'b010000, 6'b010000);
        step(mk(1, 20, 1, 0, 0, 5, 1, 0), 0, "st_run",   2'b11, 6'b000000, 6'b000000);
        // Async reset mid-flush
        step(mk(1, 5, 1, 0, 0, 5, 1, 0), 1, "jump2",     2'b11, 6'b010000, 6'b010000);
        drive(mk(1, 5, 1, 5, 1, 6, 1, 0), 0);
        #1;
        model_eval(0, mk(1, 5, 1, 5, 1, 6, 1, 0), 0);
        model_eval(1, mk(1, 5, 1, 5, 1, 6, 1, 0), 0);
        chk("pre_rst/a", out_a, exp_o[0]);
        chk("pre_rst/b", out_b, exp_o[1]);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_a", out_a, 6'b0);
        chk("async_rst_b", out_b, 6'b0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_a", out_a, 6'b0);
        rst = 1'b0;
        model_reset();
        step(mk(1, 5, 1, 5, 1, 8, 1, 0), 0, "post_rst",  2'b11, 6'b000000, 6'b000000);
        step(mk(1, 8, 1, 5, 1, 6, 1, 0), 0, "post_dep",  2'b11, 6'b001000, 6'b001000);

        // Random traffic over a small register set for dense hazards
        for (int n = 0; n < 1500; n++) begin
            r.v   = $urandom_range(0, 9) != 0;
            r.rs1 = W'($urandom_range(0, 6));
            r.rs2 = W'($urandom_range(0, 6));
            r.u1  = $urandom_range(0, 3) != 0;
            r.u2  = $urandom_range(0, 2) != 0;
            r.rd  = W'($urandom_range(0, 6));
            r.wb  = $urandom_range(0, 4) != 0;
            r.ld  = $urandom_range(0, 2) == 0;
            j = (frem[0] == 0) && (frem[1] == 0) && ($urandom_range(0, 11) == 0);
            step(r, j, "rand", 2'b00, 6'b0, 6'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
